// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences PLL reset/retry, gates core reset on stable lock, and divides the pixel clock-enable
module pll_lock_supervisor #(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int STABLE_CYCLES  = 1024,
  parameter int CE_DIV         = 4,
  parameter int LOSS_CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pll_locked,
  input  logic                  clr_loss,
  output logic                  pll_rst,
  output logic                  core_reset,
  output logic                  ready,
  output logic                  ce_pix,
  output logic [LOSS_CNT_W-1:0] loss_count
);
  localparam int MAXC = (TIMEOUT_CYCLES > STABLE_CYCLES) ?
                        ((TIMEOUT_CYCLES > PLL_RST_CYCLES) ? TIMEOUT_CYCLES : PLL_RST_CYCLES) :
                        ((STABLE_CYCLES > PLL_RST_CYCLES) ? STABLE_CYCLES : PLL_RST_CYCLES);
  localparam int CW = ($clog2(MAXC) < 1) ? 1 : $clog2(MAXC);
  localparam int DW = ($clog2(CE_DIV) < 1) ? 1 : $clog2(CE_DIV);
  localparam logic [CW-1:0] RST_END = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_END  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] ST_END  = CW'(STABLE_CYCLES - 1);
  localparam logic [DW-1:0] DIV_END = DW'(CE_DIV - 1);
  typedef enum logic [1:0] {PLL_RST, WAIT_LOCK, STABLE, RUN} state_t;
  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic [DW-1:0]           div_q, div_d;
  logic                    ce_q, ce_d;
  logic [LOSS_CNT_W-1:0]   loss_q, loss_d;
  logic                    lk_s, loss_inc;
  assign lk_s       = sync_q[SYNC_STAGES-1];
  assign pll_rst    = state_q == PLL_RST;
  assign core_reset = state_q != RUN;
  assign ready      = state_q == RUN;
  assign ce_pix     = ce_q;
  assign loss_count = loss_q;
  // Lock indication shifts through the synchronizer chain, newest sample at bit 0
  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], pll_locked};
  // Sequencer next state, shared counter, pixel divider and loss counter
  always_comb begin
    state_d  = state_q;
    loss_inc = 1'b0;
    case (state_q)
      PLL_RST:   if (cnt_q == RST_END) state_d = WAIT_LOCK;
      WAIT_LOCK: state_d = lk_s ? STABLE : (cnt_q == TO_END) ? PLL_RST : WAIT_LOCK;
      STABLE:    state_d = !lk_s ? WAIT_LOCK : (cnt_q == ST_END) ? RUN : STABLE;
      default: begin
        state_d  = lk_s ? RUN : WAIT_LOCK;
        loss_inc = !lk_s;
      end
    endcase
    cnt_d  = (state_d != state_q || state_q == RUN) ? '0 : cnt_q + 1'b1;
    div_d  = (state_d == RUN && state_q == RUN && div_q != DIV_END) ? div_q + 1'b1 : '0;
    ce_d   = state_d == RUN && div_d == '0;
    loss_d = clr_loss ? '0 : (loss_inc && !(&loss_q)) ? loss_q + 1'b1 : loss_q;
  end
  // State registers with asynchronous reset into the PLL reset phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PLL_RST;
      cnt_q   <= '0;
      sync_q  <= '0;
      div_q   <= '0;
      ce_q    <= 1'b0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sync_q  <= sync_d;
      div_q   <= div_d;
      ce_q    <= ce_d;
      loss_q  <= loss_d;
    end
  end
endmodule
